// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the universal shift register.
// State encoding and shift direction codes.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_burst_ctr.sv
// Burst length down-counter with clamp to the register width.
// Loaded on burst start; flags the cycle carrying the final shift.
module shift_burst_ctr
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             dec,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_clamped;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign last = (cnt == CNT_W'(1));

  // Remaining-shift counter: clear on abort, load on start, count down per shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= len_clamped;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: load, bidirectional shift/rotate, burst engine.
// Optional registered parity output enabled by SHIFT_REG_PARITY_EN.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic             rotate,
  input  logic [WIDTH-1:0] I,
  input  logic             SI_R,
  input  logic             SI_L,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] A,
  output logic             SO,
  output logic             busy,
`ifdef SHIFT_REG_PARITY_EN
  output logic             par,
`endif
  output logic             done
);

  state_t           state;
  state_t           state_nx;
  logic             cap_dir;
  logic             cap_rot;
  logic             cap_en;
  logic [WIDTH-1:0] a_nx;
  logic             ctr_ld;
  logic             ctr_dec;
  logic             ctr_clr;
  logic             last;
  logic             eff_dir;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic             d,
    input logic             r,
    input logic             sr,
    input logic             sl
  );
    if (d == DIR_RIGHT) begin
      return {(r ? v[0] : sr), v[WIDTH-1:1]};
    end else begin
      return {v[WIDTH-2:0], (r ? v[WIDTH-1] : sl)};
    end
  endfunction

  shift_burst_ctr #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_ctr (
    .clk (clk),
    .rst (rst),
    .ld  (ctr_ld),
    .dec (ctr_dec),
    .clr (ctr_clr),
    .len (len),
    .last(last)
  );

  // Next state and next register value: load beats burst beats manual shift.
  always_comb begin
    state_nx = state;
    a_nx     = A;
    ctr_ld   = 1'b0;
    ctr_dec  = 1'b0;
    ctr_clr  = 1'b0;
    cap_en   = 1'b0;
    if (load) begin
      a_nx     = I;
      ctr_clr  = (state == ST_RUN);
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_RUN: begin
          a_nx    = shift_step(A, cap_dir, cap_rot, SI_R, SI_L);
          ctr_dec = 1'b1;
          if (last) state_nx = ST_DONE;
        end
        ST_DONE: begin
          state_nx = ST_IDLE;
        end
        default: begin
          if (start) begin
            if (len == '0) begin
              state_nx = ST_DONE;
            end else begin
              ctr_ld   = 1'b1;
              cap_en   = 1'b1;
              state_nx = ST_RUN;
            end
          end else if (shift) begin
            a_nx = shift_step(A, dir, rotate, SI_R, SI_L);
          end
        end
      endcase
    end
  end

  // State, data and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      A       <= '0;
      cap_dir <= 1'b0;
      cap_rot <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nx;
      A     <= a_nx;
      busy  <= (state_nx == ST_RUN);
      done  <= (state_nx == ST_DONE);
      if (cap_en) begin
        cap_dir <= dir;
        cap_rot <= rotate;
      end
    end
  end

  assign eff_dir = (state == ST_RUN) ? cap_dir : dir;
  assign SO = (eff_dir == DIR_LEFT) ? A[WIDTH-1] : A[0];

`ifdef SHIFT_REG_PARITY_EN
  // Even-parity flag tracking the value A takes on each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else begin
      par <= ^a_nx;
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal (WIDTH=8).
// Reference model plus directed scenarios with literal expectations.
module tb_shift_reg_universal;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       shift = 1'b0;
  logic       dir = 1'b0;
  logic       rotate = 1'b0;
  logic [7:0] I = 8'h00;
  logic       SI_R = 1'b0;
  logic       SI_L = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = 4'd0;
  logic [7:0] A;
  logic       SO;
  logic       busy;
  logic       done;
`ifdef SHIFT_REG_PARITY_EN
  logic       par;
`endif

  int checks = 0;
  int passes = 0;

  shift_reg_universal #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .dir   (dir),
    .rotate(rotate),
    .I     (I),
    .SI_R  (SI_R),
    .SI_L  (SI_L),
    .start (start),
    .len   (len),
    .A     (A),
    .SO    (SO),
    .busy  (busy),
`ifdef SHIFT_REG_PARITY_EN
    .par   (par),
`endif
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else
      passes++;
  endtask

  // Reference model: arithmetic shifts, phase 0=idle 1=burst 2=done.
  logic [7:0] m_a = 8'h00;
  int         m_ph = 0;
  int         m_rem = 0;
  logic       m_dir = 1'b0;
  logic       m_rot = 1'b0;

  function automatic logic [7:0] mshift(input logic [7:0] v, input logic d,
                                        input logic r, input logic sr,
                                        input logic sl);
    logic b;
    if (!d) begin
      b = r ? v[0] : sr;
      return (v >> 1) | (b ? 8'h80 : 8'h00);
    end
    b = r ? v[7] : sl;
    return (v << 1) | {7'd0, b};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a   <= 8'h00;
      m_ph  <= 0;
      m_rem <= 0;
      m_dir <= 1'b0;
      m_rot <= 1'b0;
    end else if (load) begin
      m_a  <= I;
      m_ph <= 0;
    end else if (m_ph == 1) begin
      m_a   <= mshift(m_a, m_dir, m_rot, SI_R, SI_L);
      m_rem <= m_rem - 1;
      m_ph  <= (m_rem == 1) ? 2 : 1;
    end else if (m_ph == 2) begin
      m_ph <= 0;
    end else if (start) begin
      if (len == 0) begin
        m_ph <= 2;
      end else begin
        m_rem <= (int'(len) > W) ? W : int'(len);
        m_dir <= dir;
        m_rot <= rotate;
        m_ph  <= 1;
      end
    end else if (shift) begin
      m_a <= mshift(m_a, dir, rotate, SI_R, SI_L);
    end
  end

  // Compare every cycle, mid-period, while out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_A", A, m_a);
      check("model_busy", busy, m_ph == 1);
      check("model_done", done, m_ph == 2);
      check("model_SO", SO,
            ((m_ph == 1) ? m_dir : dir) ? m_a[7] : m_a[0]);
`ifdef SHIFT_REG_PARITY_EN
      check("model_par", par, ^m_a);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic burst_watch(output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) nb++;
      if (done) nd++;
      tick();
    end
  endtask

  initial begin
    int nb;
    int nd;
    tick();
    tick();
    rst = 1'b0;
    check("reset_A", A, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);

    load = 1'b1; I = 8'hA5;
    tick();
    load = 1'b0;
    check("load_A5", A, 8'hA5);
    dir = 1'b0; rotate = 1'b0; SI_R = 1'b1; shift = 1'b1;
    tick();
    shift = 1'b0; SI_R = 1'b0;
    check("shr_D2", A, 8'hD2);
    check("shr_SO", SO, 1'b0);

    load = 1'b1; I = 8'h81;
    tick();
    load = 1'b0;
    dir = 1'b1; rotate = 1'b1; len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; dir = 1'b0; rotate = 1'b0;
    burst_watch(nb, nd);
    check("rotl3_busy_cycles", nb, 3);
    check("rotl3_done_cycles", nd, 1);
    check("rotl3_A", A, 8'h0C);

    load = 1'b1; I = 8'h3C;
    tick();
    load = 1'b0;
    dir = 1'b0; rotate = 1'b1; len = 4'd15; start = 1'b1;
    tick();
    start = 1'b0; rotate = 1'b0;
    burst_watch(nb, nd);
    check("clamp_busy_cycles", nb, 8);
    check("clamp_done_cycles", nd, 1);
    check("clamp_A", A, 8'h3C);

    len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_busy", busy, 1'b0);
    check("zero_done", done, 1'b1);
    check("zero_A", A, 8'h3C);
    tick();
    check("zero_done_drop", done, 1'b0);

    dir = 1'b0; rotate = 1'b0; SI_R = 1'b0; len = 4'd5; start = 1'b1;
    tick();
    shift = 1'b1; dir = 1'b1;
    tick();
    check("run1_A", A, 8'h1E);
    check("run1_busy", busy, 1'b1);
    start = 1'b0; shift = 1'b0; load = 1'b1; I = 8'hFF;
    tick();
    load = 1'b0;
    check("abort_A", A, 8'hFF);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    burst_watch(nb, nd);
    check("abort_no_done", nd, 0);
    check("abort_hold_A", A, 8'hFF);

    load = 1'b1; I = 8'hA5;
    tick();
    load = 1'b0;
    dir = 1'b1; len = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    check("arst_A", A, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
`ifdef SHIFT_REG_PARITY_EN
    check("arst_par", par, 1'b0);
`endif
    tick();
    rst = 1'b0;
    load = 1'b1; I = 8'h07;
    tick();
    check("post_A07", A, 8'h07);
`ifdef SHIFT_REG_PARITY_EN
    check("par_07", par, 1'b1);
`endif
    I = 8'h03;
    tick();
    load = 1'b0;
    check("post_A03", A, 8'h03);
`ifdef SHIFT_REG_PARITY_EN
    check("par_03", par, 1'b0);
`endif
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised successor to the team's 4-bit load/shift register.
- Generalised to WIDTH bits, with bidirectional shift and an optional rotate mode.
- Adds an autonomous burst engine that shifts a programmed number of positions and reports busy/done.
- Used as a serialiser/deserialiser front end in the datapath exercises; one instance per serial channel.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, $clog2(WIDTH+1), derived localparam; width of burst length/counter (not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
load  input  1  parallel load of I into A
shift  input  1  manual single-step shift while idle
dir  input  1  0 = shift right (toward bit 0), 1 = shift left (toward bit WIDTH-1)
rotate  input  1  1 = bit leaving is recirculated instead of the serial input
I  input  WIDTH  parallel load data
SI_R  input  1  serial input entering bit WIDTH-1 on a right shift
SI_L  input  1  serial input entering bit 0 on a left shift
start  input  1  launch a burst of len shifts
len  input  CNT_W  burst length; values above WIDTH are clamped to WIDTH
A  output  WIDTH  register contents
SO  output  1  serial output: A[0] when the effective dir is right, A[WIDTH-1] when left (combinational)
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async, active-high): A=0, state=IDLE, counter=0, captured dir/rotate=0, busy=0, done=0. Reset has priority over everything, mid-burst included.
- State machine IDLE/RUN/DONE, registered outputs:
  - busy=1 only in RUN.
  - done=1 only in DONE.
- Per-edge priority: load > RUN shift > manual shift > hold.
- load:
  - A<=I in any state.
  - In RUN, the burst aborts: next state IDLE, no done pulse.
  - load together with start in IDLE: load wins and start is ignored.
- Shift right: A <= {in, A[WIDTH-1:1]}, where in = rotate ? A[0] : SI_R.
- Shift left: A <= {A[WIDTH-2:0], in}, where in = rotate ? A[WIDTH-1] : SI_L.
- IDLE:
  - shift=1 (no load, no start): one step using the live dir/rotate.
  - start=1 with len>0: capture dir, rotate and min(len,WIDTH) into the counter; go to RUN. No shift on the capture edge.
  - start=1 with len=0: go to DONE directly, A unchanged.
  - start has priority over shift.
- RUN:
  - One shift per cycle using the captured dir/rotate; counter decrements.
  - The edge that performs the last shift (counter==1) moves to DONE.
  - Exactly N shifts for N=min(len,WIDTH); the done pulse appears the cycle after the final A update.
  - start and shift are ignored while in RUN.
  - SI_R/SI_L are sampled live each cycle.
- DONE: one cycle, then IDLE. A start in DONE is ignored.
- SO follows the captured dir in RUN and the live dir otherwise.
- Rotate with len=WIDTH restores the original A after the burst.

Optional Feature:
- Macro: SHIFT_REG_PARITY_EN.
- When defined:
  - Adds output port par (1 bit), a registered even-parity flag: par = XOR of the next value of A, updated on every edge.
  - par resets to 0.
- When undefined: the port is absent and no parity logic is generated.

Decomposition:
- Package shift_reg_pkg:
  - state enum ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
- Sub-module shift_burst_ctr:
  - Contains the CNT_W down-counter with clamp.
  - Has a load-on-start input and a last-shift flag output.
- The register datapath and FSM stay in the top module.

Test Plan:
- Reset, parallel load, manual shift (WIDTH=8):
  - Stimulus: rst pulse, then load I=8'hA5, then one manual right shift with SI_R=1, rotate=0.
  - Required: A=00 after reset, then A5, then A=D2, with SO=0 after the shift.
- Left rotate burst:
  - Stimulus: A=8'h81, dir=1, rotate=1, start with len=3.
  - Required: busy high for 3 cycles, A=8'h0C, done high for exactly 1 cycle after the final update.
- len clamp and rotate restore:
  - Stimulus: A=8'h3C, len=15, dir=0, rotate=1.
  - Required: exactly 8 shifts, final A=8'h3C, then done.
- Zero-length burst:
  - Stimulus: start with len=0.
  - Required: no busy, A unchanged, done pulses on the next cycle.
- Abort by load:
  - Stimulus: load I=8'hFF on the 2nd RUN cycle of a len=5 burst.
  - Required: A=FF, busy drops, no done; start and shift during RUN have no effect.
- Async reset mid-burst:
  - Stimulus: assert rst between clock edges during RUN.
  - Required: A=0, busy=0, done=0 immediately; with SHIFT_REG_PARITY_EN defined, par=0 and par tracks ^A after subsequent loads.
